button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Upstream conditioning stage between the raw board push-button and the CPU reset.
//  Synchronises BUTTON to CLK and debounces it with a 4-state FSM.
//  Emits a clean level plus one-cycle press/release pulses.
//  Produces CPU_RESET, a glitch-free stretched reset for the cpu core that replaces direct BUTTON->RESET wiring.
// PARAMETERS
//  DEBOUNCE_CYCLES  500_000  cycles BUTTON must be stable before the level changes (>=1)
//  STRETCH_CYCLES   16       cycles CPU_RESET stays high after RESET drops or BTN_LEVEL falls (>=1)
// PORTS
//  CLK          in   1  system clock; sole clock domain
//  RESET        in   1  synchronous, active-high reset
//  BUTTON       in   1  raw asynchronous push-button, bouncy
//  BTN_LEVEL    out  1  debounced button level
//  BTN_PRESS    out  1  one-cycle pulse on debounced rising edge
//  BTN_RELEASE  out  1  one-cycle pulse on debounced falling edge
//  CPU_RESET    out  1  stretched reset for downstream cpu, driven from registers only
// BEHAVIOUR
//  Reset (RESET=1 at a CLK edge)
//   - sync FFs=0, state=RELEASED, debounce cnt=0, stretch cnt=STRETCH_CYCLES.
//   - Outputs: BTN_LEVEL=0, BTN_PRESS=0, BTN_RELEASE=0, CPU_RESET=1.
//   - Applies mid-debounce/mid-stretch too; no pulse is emitted in or after a reset cycle.
//  Synchroniser
//   - 2-FF chain; btn_s = second stage. No logic touches BUTTON before stage 1.
//  FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT
//   - RELEASED: btn_s=1 -> PRESS_WAIT, cnt<=0.
//   - PRESS_WAIT, btn_s=0: -> RELEASED (bounce rejected, no pulse).
//   - PRESS_WAIT, btn_s=1: cnt==DEBOUNCE_CYCLES-1 -> PRESSED; else cnt++.
//   - PRESSED: btn_s=0 -> RELEASE_WAIT, cnt<=0.
//   - RELEASE_WAIT, btn_s=1: -> PRESSED, no pulse.
//   - RELEASE_WAIT, btn_s=0: cnt==DEBOUNCE_CYCLES-1 -> RELEASED; else cnt++.
//   - Counter width $clog2(DEBOUNCE_CYCLES)+1; counter never wraps (compare stops it).
//  Outputs
//   - BTN_LEVEL = (state==PRESSED || state==RELEASE_WAIT), decoded from the state register.
//   - BTN_PRESS: registered; high for exactly the first cycle BTN_LEVEL=1.
//   - BTN_RELEASE: registered; high for exactly the first cycle BTN_LEVEL returns to 0.
//   - BTN_PRESS and BTN_RELEASE are never high in the same cycle.
//  Latency
//   - BUTTON held stable: BTN_LEVEL changes after the (DEBOUNCE_CYCLES+3)th CLK edge.
//   - Edge count starts at 1 on the first edge that samples the new BUTTON value.
//   - Same latency for press and release.
//  Stretch counter scnt (width $clog2(STRETCH_CYCLES)+1)
//   - RESET -> scnt<=STRETCH_CYCLES.
//   - else BTN_LEVEL=1 -> scnt<=STRETCH_CYCLES.
//   - else scnt!=0 -> scnt--.
//   - CPU_RESET = BTN_LEVEL | (scnt!=0).
//  CPU_RESET timing
//   - Stays high exactly STRETCH_CYCLES cycles after the last RESET=1 edge.
//   - Likewise STRETCH_CYCLES cycles after BTN_LEVEL falls.
//   - A new press during the stretch keeps CPU_RESET high continuously (no low gap).
// TESTING (bench uses DEBOUNCE_CYCLES=4, STRETCH_CYCLES=3)
//  1 Reset release, BUTTON=0 -> CPU_RESET=1 for 3 cycles after RESET drops, then 0.
//    All other outputs stay 0.
//  2 BUTTON 0->1 held -> BTN_LEVEL rises after edge 7; BTN_PRESS=1 for that one cycle only.
//    CPU_RESET=1 while BTN_LEVEL=1.
//  3 BUTTON high for 3 cycles then low (bounce) -> BTN_LEVEL, BTN_PRESS, BTN_RELEASE stay 0.
//  4 From PRESSED, BUTTON 1->0 held -> BTN_LEVEL falls after edge 7 with one-cycle BTN_RELEASE.
//    CPU_RESET falls exactly 3 cycles after BTN_LEVEL.
//  5 From PRESSED, BUTTON low 2 cycles then high again -> BTN_LEVEL stays 1, no BTN_RELEASE.
//  6 RESET asserted during PRESS_WAIT (cnt=2) -> next cycle state=RELEASED, cnt=0, CPU_RESET=1.
//    Re-debounce after reset takes the full 7 edges.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button-side signal bundle for button_conditioner.
// The bench drives BUTTON through master; the conditioner uses slave.
interface button_conditioner_if;
  logic BUTTON;
  logic BTN_LEVEL;
  logic BTN_PRESS;
  logic BTN_RELEASE;
  logic CPU_RESET;

  modport master (
    output BUTTON,
    input  BTN_LEVEL,
    input  BTN_PRESS,
    input  BTN_RELEASE,
    input  CPU_RESET
  );

  modport slave (
    input  BUTTON,
    output BTN_LEVEL,
    output BTN_PRESS,
    output BTN_RELEASE,
    output CPU_RESET
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw push-button, emits press/release pulses
// and a stretched, register-derived CPU reset.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int STRETCH_CYCLES  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  button_conditioner_if.slave   btn
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SW = $clog2(STRETCH_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCNT_START = SW'(STRETCH_CYCLES);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic          sync1;
  logic          btn_s;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scnt;
  logic          press;
  logic          release_q;
  logic          level;

  // BUTTON goes straight into the first flop with nothing in front of it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn.BUTTON;
      btn_s <= sync1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= RELEASED;
      cnt       <= '0;
      press     <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press     <= 1'b0;
      release_q <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= RELEASED;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state     <= RELEASED;
            release_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign level = (state == PRESSED) || (state == RELEASE_WAIT);

  // Reloaded while the button is held, so a re-press during the stretch leaves no gap.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scnt <= SCNT_START;
    end else if (level) begin
      scnt <= SCNT_START;
    end else if (scnt != '0) begin
      scnt <= scnt - SW'(1);
    end
  end

  assign btn.BTN_LEVEL   = level;
  assign btn.BTN_PRESS   = press;
  assign btn.BTN_RELEASE = release_q;
  assign btn.CPU_RESET   = level | (scnt != '0);

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner, checked every cycle
// against a run-length debounce model with DEBOUNCE_CYCLES=4, STRETCH_CYCLES=3.
module tb_button_conditioner;
  localparam int DEB = 4;
  localparam int STR = 3;

  logic CLK = 1'b0;
  logic RESET;
  int   compared = 0;
  int   mismatched = 0;

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .STRETCH_CYCLES (STR)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .btn  (bif.slave)
  );

  always #5 CLK = ~CLK;

  // Model: level flips once the synchronised button has disagreed with it
  // for DEB+1 consecutive edges; since_cause counts edges since reset or a held level.
  logic sync_pipe [2];
  logic m_level;
  logic m_press;
  logic m_release;
  int   run_len;
  int   since_cause;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0b expected %0b", tag, $time, observed, expected);
    end
  endtask

  task automatic modelEdge(input logic b, input logic r);
    logic old_level;
    old_level = m_level;
    if (r) begin
      sync_pipe[0] = 1'b0;
      sync_pipe[1] = 1'b0;
      m_level      = 1'b0;
      run_len      = 0;
      since_cause  = 0;
      m_press      = 1'b0;
      m_release    = 1'b0;
    end else begin
      if (sync_pipe[1] != m_level) run_len++;
      else run_len = 0;
      if (run_len == DEB + 1) begin
        m_level = !m_level;
        run_len = 0;
      end
      m_press   = !old_level && m_level;
      m_release = old_level && !m_level;
      if (old_level) since_cause = 0;
      else if (since_cause < STR) since_cause++;
      sync_pipe[1] = sync_pipe[0];
      sync_pipe[0] = b;
    end
  endtask

  task automatic applyStimulus(input logic b, input logic r);
    bif.BUTTON = b;
    RESET      = r;
    @(posedge CLK);
    modelEdge(b, r);
    #1;
    checkOutput("level",   bif.BTN_LEVEL,   m_level);
    checkOutput("press",   bif.BTN_PRESS,   m_press);
    checkOutput("release", bif.BTN_RELEASE, m_release);
    checkOutput("cpu_rst", bif.CPU_RESET,   m_level || (since_cause < STR));
    if (bif.BTN_PRESS && bif.BTN_RELEASE)
      checkOutput("press_and_release", 1'b1, 1'b0);
  endtask

  initial begin
    sync_pipe[0] = 1'b0;
    sync_pipe[1] = 1'b0;
    m_level = 1'b0; m_press = 1'b0; m_release = 1'b0;
    run_len = 0; since_cause = 0;
    bif.BUTTON = 1'b0;
    RESET = 1'b1;

    // Reset release with the button idle: CPU_RESET holds three cycles then drops.
    applyStimulus(1'b0, 1'b1);
    checkOutput("rst_cpu", bif.CPU_RESET, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("rst_stretch", bif.CPU_RESET, e < STR);
      checkOutput("rst_level", bif.BTN_LEVEL, 1'b0);
    end

    // Clean press: level rises on edge 7 with a single press pulse.
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("lat_press_level", bif.BTN_LEVEL, e >= DEB + 3);
      checkOutput("lat_press_pulse", bif.BTN_PRESS, e == DEB + 3);
    end

    // Short release glitch while pressed is absorbed.
    for (int e = 1; e <= 2; e++) applyStimulus(1'b0, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("glitch_level", bif.BTN_LEVEL, 1'b1);
      checkOutput("glitch_release", bif.BTN_RELEASE, 1'b0);
    end

    // Clean release: level falls on edge 7, CPU_RESET three cycles later.
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("lat_rel_level", bif.BTN_LEVEL, e < DEB + 3);
      checkOutput("lat_rel_pulse", bif.BTN_RELEASE, e == DEB + 3);
      checkOutput("lat_rel_cpu", bif.CPU_RESET, e < DEB + 3 + STR);
    end

    // Three-cycle bounce never reaches the level.
    for (int e = 1; e <= 3; e++) applyStimulus(1'b1, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("bounce_level", bif.BTN_LEVEL, 1'b0);
      checkOutput("bounce_press", bif.BTN_PRESS, 1'b0);
    end

    // Reset mid press-debounce, then a full re-debounce.
    for (int e = 1; e <= 5; e++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_rst_level", bif.BTN_LEVEL, 1'b0);
    checkOutput("mid_rst_cpu", bif.CPU_RESET, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("redeb_level", bif.BTN_LEVEL, e >= DEB + 3);
    end

    // Random holds of varying length with occasional resets.
    for (int seg = 0; seg < 150; seg++) begin
      logic b;
      int   len;
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++)
        applyStimulus(b, ($urandom_range(0, 59) == 0));
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
